// File: rtl/affine_filt_pkg.sv
// rtl/affine_filt_pkg.sv - coefficient table, tap count and state type shared by the affine row filter
package affine_filt_pkg;

  localparam int NTAPS  = 6;
  localparam int COEF_W = 8;
  localparam int FRAC_N = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } fsm_t;

  // Row f interpolates phase f/16; every row sums to 64, so a flat input gains exactly 64.
  localparam logic signed [COEF_W-1:0] COEF [FRAC_N][NTAPS] = '{
    '{ 8'sd0,   8'sd0,  8'sd64,  8'sd0,   8'sd0,  8'sd0},
    '{ 8'sd1,  -8'sd3,  8'sd63,  8'sd4,  -8'sd2,  8'sd1},
    '{ 8'sd1,  -8'sd5,  8'sd62,  8'sd8,  -8'sd3,  8'sd1},
    '{ 8'sd2,  -8'sd8,  8'sd60,  8'sd13, -8'sd4,  8'sd1},
    '{ 8'sd3, -8'sd10,  8'sd58,  8'sd17, -8'sd5,  8'sd1},
    '{ 8'sd3, -8'sd11,  8'sd52,  8'sd26, -8'sd8,  8'sd2},
    '{ 8'sd2,  -8'sd9,  8'sd47,  8'sd31, -8'sd10, 8'sd3},
    '{ 8'sd3, -8'sd11,  8'sd45,  8'sd34, -8'sd10, 8'sd3},
    '{ 8'sd3, -8'sd11,  8'sd40,  8'sd40, -8'sd11, 8'sd3},
    '{ 8'sd3, -8'sd10,  8'sd34,  8'sd45, -8'sd11, 8'sd3},
    '{ 8'sd3, -8'sd10,  8'sd31,  8'sd47, -8'sd9,  8'sd2},
    '{ 8'sd2,  -8'sd8,  8'sd26,  8'sd52, -8'sd11, 8'sd3},
    '{ 8'sd1,  -8'sd5,  8'sd17,  8'sd58, -8'sd10, 8'sd3},
    '{ 8'sd1,  -8'sd4,  8'sd13,  8'sd60, -8'sd8,  8'sd2},
    '{ 8'sd1,  -8'sd3,  8'sd8,   8'sd62, -8'sd5,  8'sd1},
    '{ 8'sd1,  -8'sd2,  8'sd4,   8'sd63, -8'sd3,  8'sd1}
  };

  function automatic int round_off(input int shift);
    if (shift > 0) return 1 << (shift - 1);
    return 0;
  endfunction

endpackage

// File: rtl/affine_tap_mult.sv
// rtl/affine_tap_mult.sv - one filter tap: phase-selected constant times an unsigned sample
module affine_tap_mult
  import affine_filt_pkg::*;
#(
  parameter int TAP    = 0,
  parameter int IN_W   = 8,
  parameter int PROD_W = IN_W + COEF_W
) (
  input  logic [3:0]               frac_i,
  input  logic [IN_W-1:0]          pix_i,
  output logic signed [PROD_W-1:0] prod_o
);

  logic signed [PROD_W-1:0] px;

  assign px = PROD_W'(pix_i);

  function automatic logic signed [PROD_W-1:0] c(input int f);
    return PROD_W'(COEF[f][TAP]);
  endfunction

  // Each branch is a multiply by a fixed constant, so it reduces to shifts and adds.
  always_comb begin
    prod_o = '0;
    case (frac_i)
      4'd0:  prod_o = px * c(0);
      4'd1:  prod_o = px * c(1);
      4'd2:  prod_o = px * c(2);
      4'd3:  prod_o = px * c(3);
      4'd4:  prod_o = px * c(4);
      4'd5:  prod_o = px * c(5);
      4'd6:  prod_o = px * c(6);
      4'd7:  prod_o = px * c(7);
      4'd8:  prod_o = px * c(8);
      4'd9:  prod_o = px * c(9);
      4'd10: prod_o = px * c(10);
      4'd11: prod_o = px * c(11);
      4'd12: prod_o = px * c(12);
      4'd13: prod_o = px * c(13);
      4'd14: prod_o = px * c(14);
      4'd15: prod_o = px * c(15);
      default: prod_o = '0;
    endcase
  end

endmodule

// File: rtl/affine_row_filter.sv
// rtl/affine_row_filter.sv - streaming 6-tap horizontal affine luma filter with a two-stage pipeline
// Build option: define AFFINE_ROW_SAT_EN to saturate results to OUT_W instead of wrapping.
module affine_row_filter
  import affine_filt_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sol,
  input  logic [3:0]              in_frac,
  input  logic [IN_W-1:0]         in_pix,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sol,
  output logic signed [OUT_W-1:0] out_data
);

  localparam int PROD_W = IN_W + COEF_W;
  localparam int SUM_W  = PROD_W + 3;
  localparam logic signed [SUM_W-1:0] ROUND = SUM_W'(round_off(SHIFT));

  fsm_t            state_q, state_d;
  logic [2:0]      fill_q, fill_d;
  logic [3:0]      frac_q, frac_d;
  logic [IN_W-1:0] win_q [NTAPS];
  logic [IN_W-1:0] win_d [NTAPS];
  logic            accept, launch, launch_sol;

  logic signed [PROD_W-1:0] prod [NTAPS];
  logic                     s1_valid_q, s1_sol_q;
  logic signed [PROD_W-1:0] s1_prod_q [NTAPS];

  logic signed [SUM_W-1:0] sum, shifted;
  logic signed [OUT_W-1:0] res;
  logic                    out_valid_q, out_sol_q, s2_en;
  logic signed [OUT_W-1:0] out_data_q;

  // Output stage frees when empty or drained; the product stage frees when empty or the output frees.
  assign s2_en     = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_en;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_sol   = out_sol_q;
  assign out_data  = out_data_q;

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    frac_d     = frac_q;
    win_d      = win_q;
    launch     = 1'b0;
    launch_sol = 1'b0;
    if (accept) begin
      if (in_sol) begin
        frac_d = in_frac;
        for (int k = 0; k < NTAPS - 1; k++) win_d[k] = '0;
        win_d[NTAPS-1] = in_pix;
        fill_d  = 3'd1;
        state_d = FILL;
      end else begin
        case (state_q)
          IDLE: ;
          FILL: begin
            for (int k = 0; k < NTAPS - 1; k++) win_d[k] = win_q[k+1];
            win_d[NTAPS-1] = in_pix;
            fill_d = fill_q + 3'd1;
            if (fill_q == 3'(NTAPS - 1)) begin
              state_d    = RUN;
              launch     = 1'b1;
              launch_sol = 1'b1;
            end
          end
          RUN: begin
            for (int k = 0; k < NTAPS - 1; k++) win_d[k] = win_q[k+1];
            win_d[NTAPS-1] = in_pix;
            launch = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fill_q  <= '0;
      frac_q  <= '0;
      for (int k = 0; k < NTAPS; k++) win_q[k] <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      frac_q  <= frac_d;
      win_q   <= win_d;
    end
  end

  // Products see the window including the sample being accepted this cycle.
  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    affine_tap_mult #(
      .TAP   (k),
      .IN_W  (IN_W),
      .PROD_W(PROD_W)
    ) u_tap (
      .frac_i(frac_q),
      .pix_i (win_d[k]),
      .prod_o(prod[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sol_q   <= 1'b0;
      for (int k = 0; k < NTAPS; k++) s1_prod_q[k] <= '0;
    end else if (in_ready) begin
      s1_valid_q <= launch;
      s1_sol_q   <= launch_sol;
      if (launch) s1_prod_q <= prod;
    end
  end

`ifdef AFFINE_ROW_SAT_EN
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  always_comb begin
    sum = ROUND;
    for (int k = 0; k < NTAPS; k++) sum = sum + SUM_W'(s1_prod_q[k]);
    shifted = sum >>> SHIFT;
`ifdef AFFINE_ROW_SAT_EN
    if (shifted > SAT_MAX)      res = OUT_W'(SAT_MAX);
    else if (shifted < SAT_MIN) res = OUT_W'(SAT_MIN);
    else                        res = OUT_W'(shifted);
`else
    res = OUT_W'(shifted);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sol_q   <= 1'b0;
      out_data_q  <= '0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      out_sol_q   <= s1_valid_q && s1_sol_q;
      if (s1_valid_q) out_data_q <= res;
    end
  end

endmodule

// File: tb/tb_affine_row_filter.sv
// tb/tb_affine_row_filter.sv - directed and randomized checks of affine_row_filter against a row-level model
module tb_affine_row_filter;

  localparam int SHIFT = 0;
`ifdef AFFINE_ROW_SAT_EN
  localparam int BIG12 = 2047;
`else
  localparam int BIG12 = -64;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_sol = 1'b0;
  logic              out_ready = 1'b1;
  logic [3:0]        in_frac = '0;
  logic [7:0]        in_pix = '0;
  logic              in_ready, out_valid, out_sol;
  logic signed [15:0] out_data;
  logic              in_ready_n, out_valid_n, out_sol_n;
  logic signed [11:0] out_data_n;

  int checks = 0;
  int errors = 0;
  bit rnd_ready = 0;

  int coef_t [16][6] = '{
    '{0, 0, 64, 0, 0, 0},     '{1, -3, 63, 4, -2, 1},   '{1, -5, 62, 8, -3, 1},
    '{2, -8, 60, 13, -4, 1},  '{3, -10, 58, 17, -5, 1}, '{3, -11, 52, 26, -8, 2},
    '{2, -9, 47, 31, -10, 3}, '{3, -11, 45, 34, -10, 3}, '{3, -11, 40, 40, -11, 3},
    '{3, -10, 34, 45, -11, 3}, '{3, -10, 31, 47, -9, 2}, '{2, -8, 26, 52, -11, 3},
    '{1, -5, 17, 58, -10, 3}, '{1, -4, 13, 60, -8, 2},  '{1, -3, 8, 62, -5, 1},
    '{1, -2, 4, 63, -3, 1}
  };

  int exp16_q[$];
  int exp12_q[$];
  bit expsol_q[$];
  int row_q[$];
  bit row_act = 0;
  int row_frac = 0;
  int row_cnt = 0;
  int got16_q[$];
  int got12_q[$];
  bit gotsol_q[$];

  always #5 clk = ~clk;

  affine_row_filter #(.IN_W(8), .OUT_W(16), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sol(in_sol),
    .in_frac(in_frac), .in_pix(in_pix), .out_valid(out_valid), .out_ready(out_ready),
    .out_sol(out_sol), .out_data(out_data)
  );

  affine_row_filter #(.IN_W(8), .OUT_W(12), .SHIFT(SHIFT)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n), .in_sol(in_sol),
    .in_frac(in_frac), .in_pix(in_pix), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_sol(out_sol_n), .out_data(out_data_n)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  function automatic int fit(input int v, input int w);
    int mx;
    int r;
    mx = (1 << (w - 1)) - 1;
`ifdef AFFINE_ROW_SAT_EN
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
`else
    r = v & ((1 << w) - 1);
    if (r > mx) r = r - (1 << w);
    return r;
`endif
  endfunction

  task automatic model_beat(input int pix, input bit sol, input int frac);
    int sum;
    if (sol) begin
      row_q.delete();
      row_q.push_back(pix);
      row_frac = frac;
      row_act  = 1;
      row_cnt  = 1;
    end else if (row_act) begin
      row_q.push_back(pix);
      row_cnt++;
      if (row_q.size() > 6) void'(row_q.pop_front());
      if (row_cnt >= 6) begin
        sum = 0;
        for (int k = 0; k < 6; k++) sum += coef_t[row_frac][k] * row_q[k];
        sum = (sum + ((SHIFT > 0) ? (1 << (SHIFT - 1)) : 0)) >>> SHIFT;
        exp16_q.push_back(fit(sum, 16));
        exp12_q.push_back(fit(sum, 12));
        expsol_q.push_back(row_cnt == 6);
      end
    end
  endtask

  task automatic tick(output bit acc);
    bit take, s_sol, sol16, soln, vn;
    int s_pix, s_frac;
    logic signed [31:0] d16, d12;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    acc    = in_valid && in_ready;
    take   = out_valid && out_ready;
    s_sol  = in_sol;
    s_pix  = int'(in_pix);
    s_frac = int'(in_frac);
    d16    = out_data;
    d12    = out_data_n;
    sol16  = out_sol;
    soln   = out_sol_n;
    vn     = out_valid_n;
    @(posedge clk);
    #1;
    if (take) begin
      checks++;
      assert (exp16_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%0d expected=no_result", d16);
      end
      if (exp16_q.size() != 0) begin
        chk("sb_data16", d16, exp16_q.pop_front());
        chk("sb_data12", d12, exp12_q.pop_front());
        chk("sb_valid12", vn, 1);
        chk("sb_sol16", sol16, expsol_q[0]);
        chk("sb_sol12", soln, expsol_q.pop_front());
      end
      got16_q.push_back(d16);
      got12_q.push_back(d12);
      gotsol_q.push_back(sol16);
    end
    if (acc) model_beat(s_pix, s_sol, s_frac);
  endtask

  task automatic send(input int pix, input bit sol, input int frac);
    bit acc;
    acc      = 0;
    in_valid = 1'b1;
    in_pix   = 8'(pix);
    in_sol   = sol;
    in_frac  = 4'(frac);
    for (int i = 0; i < 64 && !acc; i++) tick(acc);
    chk("send_accept", acc, 1);
    in_valid = 1'b0;
    in_sol   = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) tick(acc);
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 80 && exp16_q.size() != 0; i++) tick(acc);
    chk("drain_empty", exp16_q.size(), 0);
    idle(3);
  endtask

  task automatic clear_got();
    got16_q.delete();
    got12_q.delete();
    gotsol_q.delete();
  endtask

  initial begin
    bit acc;
    int t1_exp [5];
    int f, len;
    logic signed [15:0] held;
    t1_exp = '{128, 192, 256, 320, 384};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sol", out_sol, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready_n", in_ready_n, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // frac 0 ramp: centre tap only
    clear_got();
    send(0, 1, 0);
    for (int i = 1; i < 10; i++) send(i, 0, 0);
    drain();
    chk("t1_count", got16_q.size(), 5);
    for (int i = 0; i < 5 && i < got16_q.size(); i++) begin
      chk("t1_data", got16_q[i], t1_exp[i]);
      chk("t1_sol", gotsol_q[i], i == 0);
    end

    // frac 8 single result and its latency
    clear_got();
    send(0, 1, 8);
    for (int i = 1; i < 6; i++) send(10 * i, 0, 8);
    chk("t2_lat_early", out_valid, 0);
    tick(acc);
    chk("t2_lat_valid", out_valid, 1);
    chk("t2_data", out_data, 1600);
    chk("t2_sol", out_sol, 1);
    drain();
    chk("t2_count", got16_q.size(), 1);

    // flat 255 row at frac 8
    clear_got();
    send(255, 1, 8);
    for (int i = 1; i < 8; i++) send(255, 0, 8);
    drain();
    chk("t3_count", got16_q.size(), 3);
    for (int i = 0; i < got16_q.size(); i++) begin
      chk("t3_data16", got16_q[i], 16320);
      chk("t3_data12", got12_q[i], BIG12);
    end

    // back-pressure for 3 cycles mid-stream
    clear_got();
    send(7, 1, 5);
    for (int i = 0; i < 8; i++) send($urandom_range(0, 255), 0, 5);
    in_valid  = 1'b1;
    in_pix    = 8'd99;
    in_sol    = 1'b0;
    in_frac   = 4'd5;
    out_ready = 1'b0;
    held      = out_data;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      chk("t4_hold_data", out_data, held);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_in_ready", in_ready, 0);
      chk("t4_no_accept", acc, 0);
    end
    out_ready = 1'b1;
    send(99, 0, 5);
    for (int i = 0; i < 3; i++) send($urandom_range(0, 255), 0, 5);
    drain();
    chk("t4_count", got16_q.size(), 8);

    // row restart with a new phase
    clear_got();
    send(1, 1, 0);
    for (int i = 0; i < 6; i++) send($urandom_range(0, 255), 0, 0);
    send($urandom_range(0, 255), 1, 8);
    for (int i = 0; i < 4; i++) send($urandom_range(0, 255), 0, 8);
    idle(6);
    chk("t5_rowA_count", got16_q.size(), 2);
    send($urandom_range(0, 255), 0, 8);
    drain();
    chk("t5_total", got16_q.size(), 3);
    chk("t5_b_sol", (gotsol_q.size() > 2) ? gotsol_q[2] : 1'b0, 1);

    // asynchronous reset mid-row
    send(3, 1, 2);
    for (int i = 0; i < 7; i++) send($urandom_range(0, 255), 0, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_sol", out_sol, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    exp16_q.delete();
    exp12_q.delete();
    expsol_q.delete();
    row_act = 0;
    clear_got();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send($urandom_range(0, 255), 0, 3);
    idle(4);
    chk("t6_discard", got16_q.size(), 0);

    // overflow of the 12-bit instance: saturate or wrap
    clear_got();
    send(255, 1, 0);
    for (int i = 1; i < 6; i++) send(255, 0, 0);
    tick(acc);
    chk("sat_valid", out_valid_n, 1);
    chk("sat_data12", out_data_n, BIG12);
    chk("sat_data16", out_data, 16320);
    drain();

    // randomized rows with random gaps and back-pressure
    rnd_ready = 1;
    for (int r = 0; r < 10; r++) begin
      f   = $urandom_range(0, 15);
      len = $urandom_range(5, 14);
      if (r == 4) send($urandom_range(0, 255), 0, f);
      send($urandom_range(0, 255), 1, f);
      for (int i = 1; i < len; i++) begin
        send($urandom_range(0, 255), 0, f);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    rnd_ready = 0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
